// File: rtl/pru_sync_barrier_if.sv
// Signal bundle between the PE array / sequencer and the N-channel sync barrier.
// The sequencer side drives configuration and arrivals; the barrier side reports release and status.
interface pru_sync_barrier_if #(
    parameter int N_PE      = 4,
    parameter int TIMEOUT_W = 16
);
    localparam int CNT_W = $clog2(N_PE + 1);

    logic [N_PE-1:0]      cfg_mask;
    logic [TIMEOUT_W-1:0] cfg_timeout;
    logic [N_PE-1:0]      arrive;
    logic                 clear_err;
    logic                 release_o;
    logic [N_PE-1:0]      release_vec_o;
    logic [N_PE-1:0]      waiting_o;
    logic [CNT_W-1:0]     arr_cnt_o;
    logic                 gen_o;
    logic                 busy_o;
    logic                 timeout_err_o;
    logic                 spurious_o;

    modport master (
        output cfg_mask, cfg_timeout, arrive, clear_err,
        input  release_o, release_vec_o, waiting_o, arr_cnt_o,
               gen_o, busy_o, timeout_err_o, spurious_o
    );

    modport slave (
        input  cfg_mask, cfg_timeout, arrive, clear_err,
        output release_o, release_vec_o, waiting_o, arr_cnt_o,
               gen_o, busy_o, timeout_err_o, spurious_o
    );
endinterface

// File: rtl/pru_sync_barrier.sv
// N-channel hardware barrier: collects masked PE arrivals per epoch and issues one release pulse,
// with epoch parity, a timeout watchdog and sticky error flags.
module pru_sync_barrier #(
    parameter int N_PE      = 4,
    parameter int TIMEOUT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    pru_sync_barrier_if.slave   bus
);
    localparam int CNT_W = $clog2(N_PE + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_ERROR   = 2'd3;

    function automatic logic [CNT_W-1:0] popcount(input logic [N_PE-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_PE; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [1:0]           state_r, state_nxt_s;
    logic [N_PE-1:0]      mask_r, mask_nxt_s;
    logic [N_PE-1:0]      arrived_r, arrived_nxt_s;
    logic [TIMEOUT_W-1:0] timer_r, timer_nxt_s;
    logic                 release_r, gen_r, busy_r, timeout_err_r, spurious_r;
    logic [N_PE-1:0]      release_vec_r;
    logic [N_PE-1:0]      mask_sel_s, hit_s, acc_s;
    logic [TIMEOUT_W:0]   timer_inc_s;
    logic                 timeout_hit_s, timeout_set_s, spur_evt_s;

    // The epoch mask is frozen while collecting; otherwise arrivals open an epoch under cfg_mask.
    assign mask_sel_s    = (state_r == ST_COLLECT) ? mask_r : bus.cfg_mask;
    assign hit_s         = bus.arrive & mask_sel_s;
    assign acc_s         = arrived_r | hit_s;
    assign timer_inc_s   = {1'b0, timer_r} + {{TIMEOUT_W{1'b0}}, 1'b1};
    assign timeout_hit_s = (bus.cfg_timeout != {TIMEOUT_W{1'b0}}) &&
                           (timer_inc_s >= {1'b0, bus.cfg_timeout});

    // Next-state, epoch bookkeeping and spurious-arrival detection.
    always_comb begin
        state_nxt_s   = state_r;
        mask_nxt_s    = mask_r;
        arrived_nxt_s = arrived_r;
        timer_nxt_s   = timer_r;
        timeout_set_s = 1'b0;
        spur_evt_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_RELEASE: begin
                spur_evt_s = |(bus.arrive & ~bus.cfg_mask);
                if (hit_s == {N_PE{1'b0}}) begin
                    state_nxt_s   = ST_IDLE;
                    arrived_nxt_s = {N_PE{1'b0}};
                end else begin
                    mask_nxt_s    = bus.cfg_mask;
                    arrived_nxt_s = hit_s;
                    timer_nxt_s   = {TIMEOUT_W{1'b0}};
                    state_nxt_s   = (hit_s == bus.cfg_mask) ? ST_RELEASE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                spur_evt_s    = |(bus.arrive & ~mask_r) | |(bus.arrive & arrived_r);
                arrived_nxt_s = acc_s;
                timer_nxt_s   = (&timer_r) ? timer_r : timer_inc_s[TIMEOUT_W-1:0];
                // Completion beats a watchdog expiry in the same cycle.
                if (acc_s == mask_r) begin
                    state_nxt_s = ST_RELEASE;
                end else if (timeout_hit_s) begin
                    state_nxt_s   = ST_ERROR;
                    timeout_set_s = 1'b1;
                end else begin
                    state_nxt_s = ST_COLLECT;
                end
            end
            ST_ERROR: begin
                if (bus.clear_err) begin
                    state_nxt_s   = ST_IDLE;
                    arrived_nxt_s = {N_PE{1'b0}};
                end else begin
                    state_nxt_s = ST_ERROR;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                arrived_nxt_s = {N_PE{1'b0}};
            end
        endcase
    end

    // State and registered outputs; release outputs are pre-decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            mask_r        <= {N_PE{1'b0}};
            arrived_r     <= {N_PE{1'b0}};
            timer_r       <= {TIMEOUT_W{1'b0}};
            release_r     <= 1'b0;
            release_vec_r <= {N_PE{1'b0}};
            gen_r         <= 1'b0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            spurious_r    <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            mask_r        <= mask_nxt_s;
            arrived_r     <= arrived_nxt_s;
            timer_r       <= timer_nxt_s;
            release_r     <= (state_nxt_s == ST_RELEASE);
            release_vec_r <= (state_nxt_s == ST_RELEASE) ? mask_nxt_s : {N_PE{1'b0}};
            gen_r         <= gen_r ^ (state_r == ST_RELEASE);
            busy_r        <= (state_nxt_s != ST_IDLE);
            if ((state_r == ST_ERROR) && bus.clear_err) begin
                timeout_err_r <= 1'b0;
            end else if (timeout_set_s) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
            spurious_r    <= (spurious_r & ~bus.clear_err) | spur_evt_s;
        end
    end

    assign bus.release_o     = release_r;
    assign bus.release_vec_o = release_vec_r;
    assign bus.waiting_o     = arrived_r;
    assign bus.arr_cnt_o     = popcount(arrived_r);
    assign bus.gen_o         = gen_r;
    assign bus.busy_o        = busy_r;
    assign bus.timeout_err_o = timeout_err_r;
    assign bus.spurious_o    = spurious_r;
endmodule
